layer_compositor: RTL

Parametrised pixel compositor and game-state controller for the VGA path. It merges a background pixel with LAYER_NUM prioritised sprite layers and an end-of-game overlay into one registered `rgb_out`. It also runs the PLAY / DYING / OVER state machine that replaces the single game-over flag. It sits between the sprite modules (scene, cloud, apple, button, kid, end_scene) and the VGA driver, and it drives their shared reset.

---
 rtl/layer_compositor.sv | 92 +++++++++
 1 files changed

// File: rtl/layer_compositor.sv
// layer_compositor: prioritised sprite/overlay pixel compositor with PLAY/DYING/OVER game-state control
module layer_compositor #(
  parameter int LAYER_NUM   = 4,
  parameter int RGB_W       = 12,
  parameter int FALL_LIMIT  = 600,
  parameter int DEAD_FRAMES = 30,
  parameter int CNT_W       = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [3:0]                 keys,
  input  logic [9:0]                 col,
  input  logic [9:0]                 row,
  input  logic [RGB_W-1:0]           bg_rgb,
  input  logic [LAYER_NUM-1:0]       layer_hit,
  input  logic [LAYER_NUM*RGB_W-1:0] layer_rgb,
  input  logic [LAYER_NUM-1:0]       layer_en,
  input  logic                       overlay_hit,
  input  logic [RGB_W-1:0]           overlay_rgb,
  input  logic                       hazard,
  input  logic [9:0]                 kid_y,
  output logic [RGB_W-1:0]           rgb_out,
  output logic                       game_reset,
  output logic [1:0]                 state,
  output logic [CNT_W-1:0]           death_count,
  output logic                       frame_start
);
  typedef enum logic [1:0] {PLAY = 2'd0, DYING = 2'd1, OVER = 2'd2} state_t;
  // flash_cnt must hold DEAD_FRAMES-1 and always have a bit 2 for the flash
  localparam int FW = DEAD_FRAMES > 8 ? $clog2(DEAD_FRAMES) : 3;
  localparam logic [FW-1:0] LAST = FW'(DEAD_FRAMES - 1);
  localparam logic [9:0] FALL_Y = 10'(FALL_LIMIT);
  state_t           state_q, state_d;
  logic [FW-1:0]    flash_cnt_q, flash_cnt_d;
  logic [CNT_W-1:0] death_count_q, death_count_d;
  logic [RGB_W-1:0] pix_q, pix_d, ov_rgb_q, rgb_out_q, rgb_out_d;
  logic             ov_hit_q, org_q, frame_start_q, frame_start_d, game_reset_q, game_reset_d;
  logic             at_org, unused_keys;
  assign at_org = col == 10'd0 && row == 10'd0;
  assign unused_keys = ^keys[2:0];
  always_comb begin
    pix_d = bg_rgb;
    for (int i = 0; i < LAYER_NUM; i++)
      if (layer_hit[i] && layer_en[i]) pix_d = layer_rgb[i*RGB_W +: RGB_W];
    rgb_out_d = (state_q == OVER && ov_hit_q) ? ov_rgb_q :
                (state_q == DYING && flash_cnt_q[2]) ? ~pix_q : pix_q;
    frame_start_d = at_org && !org_q;
    state_d = state_q;
    flash_cnt_d = flash_cnt_q;
    death_count_d = death_count_q;
    if (state_q == PLAY && (hazard || kid_y > FALL_Y)) begin
      state_d = DYING;
      flash_cnt_d = '0;
      death_count_d = &death_count_q ? death_count_q : death_count_q + 1'b1;
    end else if (state_q == DYING && frame_start_q) begin
      state_d = flash_cnt_q == LAST ? OVER : DYING;
      flash_cnt_d = flash_cnt_q + 1'b1;
    end else if (state_q == OVER && keys[3]) begin
      state_d = PLAY;
    end
    game_reset_d = rst || state_d == OVER;
  end
  always_ff @(posedge clk) begin
    game_reset_q <= game_reset_d;
    if (rst) begin
      state_q <= PLAY;
      flash_cnt_q <= '0;
      death_count_q <= '0;
      pix_q <= '0;
      ov_hit_q <= 1'b0;
      ov_rgb_q <= '0;
      rgb_out_q <= '0;
      org_q <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      flash_cnt_q <= flash_cnt_d;
      death_count_q <= death_count_d;
      pix_q <= pix_d;
      ov_hit_q <= overlay_hit;
      ov_rgb_q <= overlay_rgb;
      rgb_out_q <= rgb_out_d;
      org_q <= at_org;
      frame_start_q <= frame_start_d;
    end
  end
  assign rgb_out = rgb_out_q;
  assign game_reset = game_reset_q;
  assign state = state_q;
  assign death_count = death_count_q;
  assign frame_start = frame_start_q;
endmodule
